// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between NREQ
//               masters, with bounded RMW lock and read-response routing.
//               Optional macro RAM_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int NREQ     = 2,
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*AW-1:0]     req_address,
    input  logic [NREQ*DW/8-1:0]   req_byteenable,
    input  logic [NREQ*DW-1:0]     req_writedata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_readdata,
    output logic [AW-1:0]          ram_address,
    output logic [DW/8-1:0]        ram_byteenable,
    output logic                   ram_chipselect,
    output logic                   ram_write,
    output logic [DW-1:0]          ram_writedata,
    output logic                   ram_clken,
    input  logic [DW-1:0]          ram_readdata
);

    localparam int c_BEW = DW / 8;
    localparam int c_IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW  = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t        r_state;
    logic [c_IW-1:0]    r_owner;
    logic [c_CW-1:0]    r_cnt;
    logic [NREQ-1:0]    r_rsp_valid;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic [c_IW-1:0]    r_last;
`endif

    logic [c_IW-1:0]    w_win;
    logic               w_any;
    logic               w_transfer;

    // Winner selection; while locked only the owner may be granted.
    always_comb begin
        logic [c_IW-1:0] v_sel;
        int              v_idx;
        w_win = '0;
        w_any = 1'b0;
        v_sel = '0;
        v_idx = 0;
        if (r_state == S_LOCKED) begin
            w_win = r_owner;
            w_any = req_valid[r_owner];
        end else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            for (int k = NREQ - 1; k >= 0; k--) begin
                v_sel = c_IW'(k);
                if (req_valid[v_sel]) begin
                    w_win = v_sel;
                    w_any = 1'b1;
                end
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                v_idx = int'(r_last) + 1 + k;
                if (v_idx >= NREQ) begin
                    v_idx = v_idx - NREQ;
                end
                v_sel = c_IW'(v_idx);
                if (!w_any && req_valid[v_sel]) begin
                    w_win = v_sel;
                    w_any = 1'b1;
                end
            end
`endif
        end
    end

    assign w_transfer = w_any & ~reset;

    always_comb begin
        req_ready = '0;
        if (w_transfer) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        ram_chipselect = w_transfer;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (w_transfer) begin
            ram_write      = req_write[w_win];
            ram_address    = req_address[w_win*AW +: AW];
            ram_byteenable = req_byteenable[w_win*c_BEW +: c_BEW];
            ram_writedata  = req_writedata[w_win*DW +: DW];
        end
    end

    assign ram_clken    = ~reset;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_readdata = ram_readdata;

`ifndef RAM_ARB_FIXED_PRIO_EN
    // Reset to NREQ-1 so that requester 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= c_IW'(NREQ - 1);
        end else if (w_transfer) begin
            r_last <= w_win;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_transfer && !req_write[w_win]) begin
                r_rsp_valid[w_win] <= 1'b1;
            end
        end
    end

    // r_cnt counts locked transfers taken so far, including the one that took the lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_OPEN;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_OPEN: begin
                    if (w_transfer && req_lock[w_win]) begin
                        r_owner <= w_win;
                        if (LOCK_MAX > 1) begin
                            r_state <= S_LOCKED;
                            r_cnt   <= c_CW'(1);
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!req_valid[r_owner]) begin
                        r_state <= S_OPEN;
                        r_cnt   <= '0;
                    end else if (w_transfer) begin
                        if (!req_lock[r_owner] || (r_cnt >= c_CW'(LOCK_MAX - 1))) begin
                            r_state <= S_OPEN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_OPEN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter with a
//               behavioural 1024x32 RAM (registered address, 1-cycle read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [1:0]  req_lock;
    logic [19:0] req_address;
    logic [7:0]  req_byteenable;
    logic [63:0] req_writedata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_readdata;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int n_cmp;
    int n_fail;

    ram_port_arbiter #(
        .NREQ     (2),
        .AW       (10),
        .DW       (32),
        .LOCK_MAX (8)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_lock       (req_lock),
        .req_address    (req_address),
        .req_byteenable (req_byteenable),
        .req_writedata  (req_writedata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_readdata   (rsp_readdata),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backdoor port preloads contents while the DUT is held in reset.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        cyc();
        bd_we   = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_g [0:3];
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        ram_readdata = '0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_lock = 2'b00;
        req_address = {10'h020, 10'h010};
        req_byteenable = 8'hFF;
        req_writedata = '0;

        // Reset state, with requests pending.
        #2;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_cs", 64'(ram_chipselect), 64'h0);
        chk("rst_we", 64'(ram_write), 64'h0);
        chk("rst_clken", 64'(ram_clken), 64'h0);
        preload(10'h005, 32'hDEADBEEF);
        preload(10'h010, 32'h11110010);
        preload(10'h020, 32'h22220020);
        preload(10'h3FF, 32'h12345678);
        reset = 1'b0;
        req_valid = 2'b00;
        cyc();

        // Test 1: single read.
        req_valid = 2'b01;
        req_address = {10'h020, 10'h005};
        #2;
        chk("t1_ready", 64'(req_ready), 64'h1);
        chk("t1_cs", 64'(ram_chipselect), 64'h1);
        chk("t1_we", 64'(ram_write), 64'h0);
        chk("t1_addr", 64'(ram_address), 64'h005);
        chk("t1_clken", 64'(ram_clken), 64'h1);
        cyc();
        req_valid = 2'b00;
        #2;
        chk("t1_rsp", 64'(rsp_valid), 64'h1);
        chk("t1_data", 64'(rsp_readdata), 64'hDEADBEEF);
        chk("t1_idle_ready", 64'(req_ready), 64'h0);
        chk("t1_idle_cs", 64'(ram_chipselect), 64'h0);
        chk("t1_idle_addr", 64'(ram_address), 64'h0);
        cyc();

`ifndef RAM_ARB_FIXED_PRIO_EN
        // Test 2: continuous reads; pointer last=0 so req 1 goes first.
        exp_g[0] = 2'b10;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;
        exp_g[3] = 2'b01;
        req_valid = 2'b11;
        req_address = {10'h020, 10'h010};
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t2_ready", 64'(req_ready), 64'(exp_g[k]));
            chk("t2_addr", 64'(ram_address), (exp_g[k] == 2'b10) ? 64'h020 : 64'h010);
            if (k > 0) begin
                chk("t2_rsp", 64'(rsp_valid), 64'(exp_g[k-1]));
                chk("t2_data", 64'(rsp_readdata),
                    (exp_g[k-1] == 2'b10) ? 64'h22220020 : 64'h11110010);
            end
            cyc();
        end
        req_valid = 2'b00;
        #2;
        chk("t2_rsp_last", 64'(rsp_valid), 64'h1);
        chk("t2_data_last", 64'(rsp_readdata), 64'h11110010);
        cyc();
`endif

        // Test 3: byte-enabled write then read-back.
        req_valid = 2'b10;
        req_write = 2'b10;
        req_address = {10'h3FF, 10'h3FF};
        req_byteenable = 8'h3F;
        req_writedata = {32'hA5A5A5A5, 32'h0};
        #2;
        chk("t3_wr_ready", 64'(req_ready), 64'h2);
        chk("t3_wr_we", 64'(ram_write), 64'h1);
        chk("t3_wr_be", 64'(ram_byteenable), 64'h3);
        chk("t3_wr_data", 64'(ram_writedata), 64'hA5A5A5A5);
        cyc();
        req_valid = 2'b01;
        req_write = 2'b00;
        req_byteenable = 8'hFF;
        #2;
        chk("t3_rd_ready", 64'(req_ready), 64'h1);
        chk("t3_wr_norsp", 64'(rsp_valid), 64'h0);
        cyc();
        req_valid = 2'b00;
        #2;
        chk("t3_rsp", 64'(rsp_valid), 64'h1);
        chk("t3_data", 64'(rsp_readdata), 64'h1234A5A5);
        cyc();

`ifndef RAM_ARB_FIXED_PRIO_EN
        // Test 4: lock held by req 0, forced release after 8 grants.
        req_address = {10'h020, 10'h010};
        req_valid = 2'b01;
        req_lock = 2'b01;
        #2;
        chk("t4_lock_first", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b11;
        for (int k = 1; k < 8; k++) begin
            #2;
            chk("t4_locked", 64'(req_ready), 64'h1);
            cyc();
        end
        #2;
        chk("t4_forced_release", 64'(req_ready), 64'h2);
        cyc();
        #2;
        chk("t4_relock", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b10;
        #2;
        chk("t4_owner_idle", 64'(req_ready), 64'h0);
        cyc();
        #2;
        chk("t4_after_unlock", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 2'b00;
        req_lock = 2'b00;
        cyc();
`endif

        // Test 5: reset right after a read grant drops the response.
        req_address = {10'h020, 10'h010};
        req_valid = 2'b01;
        #2;
        chk("t5_ready", 64'(req_ready), 64'h1);
        cyc();
        reset = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("t5_rsp_dropped", 64'(rsp_valid), 64'h0);
        chk("t5_rst_ready", 64'(req_ready), 64'h0);
        chk("t5_rst_clken", 64'(ram_clken), 64'h0);
        cyc();
        cyc();
        reset = 1'b0;
        #2;
        chk("t5_first_grant", 64'(req_ready), 64'h1);
        chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
        cyc();
        #2;
        chk("t5_rsp", 64'(rsp_valid), 64'h1);
        chk("t5_data", 64'(rsp_readdata), 64'h11110010);
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("t5_second_grant", 64'(req_ready), 64'h1);
        cyc();
        // Test 6: fixed priority always favours req 0.
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t6_fixed", 64'(req_ready), 64'h1);
            cyc();
        end
`else
        chk("t5_second_grant", 64'(req_ready), 64'h2);
        cyc();
`endif
        req_valid = 2'b00;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
